// File: rtl/lpc_host_if.sv
// LPC host interface bundle.
// Groups the host-side request/response handshake and the LPC pad signals
// (LAD[3:0] split into in/out/oe, LFRAME#) of one lpc_host instance.
//   master : the lpc_host side (LPC bus master, request consumer)
//   slave  : the environment side (request producer, pad model / target)
interface lpc_host_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic [3:0]  lad_in;
  logic [3:0]  lad_out;
  logic        lad_oe;
  logic        lframe_n;
  logic        busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, lad_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, lad_out, lad_oe,
           lframe_n, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, lad_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, lad_out, lad_oe,
           lframe_n, busy
  );
endinterface

// File: rtl/lpc_host.sv
// LPC host for single-byte I/O read/write cycles.
// Accepts one request at a time, runs START/CTDIR/ADDR/(WDATA)/TAR/SYNC/
// (RDATA)/TAR on LAD[3:0], and returns a one-cycle completion pulse with read
// data and an error code (00 ok, 01 no response/timeout, 10 target error).
// Ports:
//   clk      LPC clock, everything changes on its rising edge
//   lpc_rst  asynchronous active-low reset
//   bus      lpc_host_if.master: request/response handshake and LAD/LFRAME#
// Parameters:
//   NORESP_LIMIT  consecutive 0xF SYNC samples before abort
//   SHORT_LIMIT   consecutive 0x5 SYNC samples before abort (0x6 unlimited)
module lpc_host #(
  parameter int NORESP_LIMIT = 4,
  parameter int SHORT_LIMIT  = 16
) (
  input  logic       clk,
  input  logic       lpc_rst,
  lpc_host_if.master bus
);

  localparam int MAX_LIMIT = (NORESP_LIMIT > SHORT_LIMIT) ? NORESP_LIMIT : SHORT_LIMIT;
  localparam int WAIT_W    = $clog2(MAX_LIMIT + 1);
  localparam logic [WAIT_W-1:0] NORESP_L = WAIT_W'(NORESP_LIMIT);
  localparam logic [WAIT_W-1:0] SHORT_L  = WAIT_W'(SHORT_LIMIT);

  typedef enum logic [3:0] {
    IDLE, START, CTDIR, ADDR, WDATA, TAR_H1, TAR_H2,
    SYNC, RDATA, TAR_T1, TAR_T2, DONE, ABORT
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        cyc, cyc_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt, run_len;
  logic [3:0]        sync_code, sync_code_nxt;
  logic              write_q, write_nxt;
  logic [7:0]        rdata_q, rdata_nxt;
  logic [1:0]        err_q, err_nxt;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic              accept;

  assign accept        = (state == IDLE) && bus.req_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Length of the run of identical SYNC codes including the current sample.
  // wait_cnt == 0 means no sample yet in this SYNC phase. Saturates so that
  // an unlimited long-wait run cannot wrap.
  always_comb begin
    run_len = WAIT_W'(1);
    if (wait_cnt != '0 && bus.lad_in == sync_code)
      run_len = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      state     <= IDLE;
      cyc       <= '0;
      wait_cnt  <= '0;
      sync_code <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nxt;
      cyc       <= cyc_nxt;
      wait_cnt  <= wait_cnt_nxt;
      sync_code <= sync_code_nxt;
      write_q   <= write_nxt;
      rdata_q   <= rdata_nxt;
      err_q     <= err_nxt;
    end
  end

  // Address/data are only consumed after acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    cyc_nxt       = '0;
    wait_cnt_nxt  = wait_cnt;
    sync_code_nxt = sync_code;
    write_nxt     = write_q;
    rdata_nxt     = rdata_q;
    err_nxt       = err_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.lframe_n  = 1'b1;
    bus.lad_oe    = 1'b0;
    bus.lad_out   = 4'hF;

    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid) begin
          state_nxt = START;
          write_nxt = bus.req_write;
          rdata_nxt = '0;
          err_nxt   = '0;
        end
      end
      START: begin
        bus.lframe_n = 1'b0;
        bus.lad_oe   = 1'b1;
        bus.lad_out  = 4'h0;
        state_nxt    = CTDIR;
      end
      CTDIR: begin
        bus.lad_oe  = 1'b1;
        bus.lad_out = write_q ? 4'h2 : 4'h0;
        state_nxt   = ADDR;
      end
      ADDR: begin
        bus.lad_oe = 1'b1;
        case (cyc)
          2'd0:    bus.lad_out = addr_q[15:12];
          2'd1:    bus.lad_out = addr_q[11:8];
          2'd2:    bus.lad_out = addr_q[7:4];
          default: bus.lad_out = addr_q[3:0];
        endcase
        if (cyc == 2'd3) state_nxt = write_q ? WDATA : TAR_H1;
        else             cyc_nxt   = cyc + 1'b1;
      end
      WDATA: begin
        bus.lad_oe  = 1'b1;
        bus.lad_out = cyc[0] ? wdata_q[7:4] : wdata_q[3:0];
        if (cyc[0]) state_nxt = TAR_H1;
        else        cyc_nxt   = 2'd1;
      end
      TAR_H1: begin
        bus.lad_oe = 1'b1;
        state_nxt  = TAR_H2;
      end
      TAR_H2: begin
        wait_cnt_nxt = '0;
        state_nxt    = SYNC;
      end
      SYNC: begin
        sync_code_nxt = bus.lad_in;
        wait_cnt_nxt  = run_len;
        case (bus.lad_in)
          4'h0: state_nxt = write_q ? TAR_T1 : RDATA;
          4'hA: begin
            state_nxt = write_q ? TAR_T1 : RDATA;
            err_nxt   = 2'b10;
          end
          4'h5: if (run_len >= SHORT_L) begin
            state_nxt = ABORT;
            err_nxt   = 2'b01;
          end
          4'h6: state_nxt = SYNC;
          4'hF: if (run_len >= NORESP_L) begin
            state_nxt = ABORT;
            err_nxt   = 2'b01;
          end
          default: begin
            state_nxt = ABORT;
            err_nxt   = 2'b01;
          end
        endcase
      end
      RDATA: begin
        if (cyc[0]) begin
          rdata_nxt[7:4] = bus.lad_in;
          state_nxt      = TAR_T1;
        end else begin
          rdata_nxt[3:0] = bus.lad_in;
          cyc_nxt        = 2'd1;
        end
      end
      TAR_T1: state_nxt = TAR_T2;
      TAR_T2: state_nxt = DONE;
      DONE: begin
        bus.rsp_valid = 1'b1;
        state_nxt     = IDLE;
      end
      ABORT: begin
        bus.lframe_n = 1'b0;
        bus.lad_oe   = 1'b1;
        rdata_nxt    = '0;
        err_nxt      = 2'b01;
        if (cyc == 2'd3) state_nxt = DONE;
        else             cyc_nxt   = cyc + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lpc_host.sv
// Testbench for lpc_host: directed LPC cycles plus randomized transactions
// checked against a frame-level reference model of the LPC I/O protocol.
module tb_lpc_host;

  localparam int NORESP = 4;
  localparam int SHORT  = 16;

  logic clk;
  logic lpc_rst;
  lpc_host_if bus ();

  lpc_host #(.NORESP_LIMIT(NORESP), .SHORT_LIMIT(SHORT)) dut (
    .clk     (clk),
    .lpc_rst (lpc_rst),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle of the expected frame: LFRAME#, output enable, driven
  // nibble (0 when not driven), what the target puts on LAD, and whether
  // this is the completion cycle.
  typedef struct packed {
    logic       fn;
    logic       oe;
    logic [3:0] out;
    logic [3:0] din;
    logic       done;
  } cyc_t;

  logic [3:0] sync_q[$];

  function automatic cyc_t mk(logic fn, logic oe, logic [3:0] out, logic [3:0] din, logic done);
    cyc_t c;
    c.fn = fn; c.oe = oe; c.out = oe ? out : 4'h0; c.din = din; c.done = done;
    return c;
  endfunction

  function automatic logic [3:0] rnib();
    return 4'($urandom_range(0, 15));
  endfunction

  // Runs one transaction. Must be called just after a rising edge while idle.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input bit hold);
    cyc_t tr[$];
    logic [7:0] exp_rdata;
    logic [1:0] exp_err;
    bit ended, aborted;
    int run;
    logic [3:0] c;
    logic [15:0] a;
    a = addr;
    tr = {};
    ended = 0; aborted = 0; exp_err = 2'b00;
    // Host-driven header
    tr.push_back(mk(1'b0, 1'b1, 4'h0, rnib(), 1'b0));
    tr.push_back(mk(1'b1, 1'b1, wr ? 4'h2 : 4'h0, rnib(), 1'b0));
    for (int i = 3; i >= 0; i--) tr.push_back(mk(1'b1, 1'b1, a[i*4 +: 4], rnib(), 1'b0));
    if (wr) begin
      tr.push_back(mk(1'b1, 1'b1, wd[3:0], rnib(), 1'b0));
      tr.push_back(mk(1'b1, 1'b1, wd[7:4], rnib(), 1'b0));
    end
    tr.push_back(mk(1'b1, 1'b1, 4'hF, rnib(), 1'b0));
    tr.push_back(mk(1'b1, 1'b0, 4'h0, rnib(), 1'b0));
    // Target SYNC: run length counted backwards over identical codes
    for (int i = 0; i < sync_q.size() && !ended; i++) begin
      c = sync_q[i];
      run = 0;
      for (int j = i; j >= 0; j--) begin
        if (sync_q[j] != c) break;
        run++;
      end
      tr.push_back(mk(1'b1, 1'b0, 4'h0, c, 1'b0));
      if (c == 4'h0 || c == 4'hA) begin
        ended = 1;
        if (c == 4'hA) exp_err = 2'b10;
      end else if ((c == 4'h5 && run >= SHORT) || (c == 4'hF && run >= NORESP)) begin
        ended = 1; aborted = 1;
      end else if (c != 4'h5 && c != 4'h6 && c != 4'hF) begin
        ended = 1; aborted = 1;
      end
    end
    if (aborted) begin
      exp_err = 2'b01;
      exp_rdata = 8'h00;
      for (int i = 0; i < 4; i++) tr.push_back(mk(1'b0, 1'b1, 4'hF, rnib(), 1'b0));
    end else begin
      exp_rdata = wr ? 8'h00 : rd;
      if (!wr) begin
        tr.push_back(mk(1'b1, 1'b0, 4'h0, rd[3:0], 1'b0));
        tr.push_back(mk(1'b1, 1'b0, 4'h0, rd[7:4], 1'b0));
      end
      tr.push_back(mk(1'b1, 1'b0, 4'h0, rnib(), 1'b0));
      tr.push_back(mk(1'b1, 1'b0, 4'h0, rnib(), 1'b0));
    end
    tr.push_back(mk(1'b1, 1'b0, 4'h0, rnib(), 1'b1));

    // Present the request in IDLE
    #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd;
    @(negedge clk);
    chk("idle_ready_busy_rsp", 32'({bus.req_ready, bus.busy, bus.rsp_valid}), 32'(3'b100));
    @(posedge clk);
    foreach (tr[k]) begin
      #1;
      bus.lad_in    = tr[k].din;
      bus.req_valid = hold ? 1'b1 : (tr[k].done ? 1'b0 : 1'($urandom_range(0, 1)));
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 8'($urandom);
      @(negedge clk);
      chk($sformatf("frame_cyc%0d", k + 1),
          32'({bus.rsp_valid, bus.busy, bus.req_ready, bus.lframe_n, bus.lad_oe,
               (tr[k].oe ? bus.lad_out : 4'h0)}),
          32'({tr[k].done, 1'b1, 1'b0, tr[k].fn, tr[k].oe, tr[k].out}));
      if (tr[k].done) begin
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      end
      @(posedge clk);
    end
  endtask

  task automatic gen_sync();
    logic [3:0] bad_codes [11];
    int groups, r, kind;
    logic [3:0] c;
    bad_codes = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE};
    sync_q.delete();
    groups = $urandom_range(0, 3);
    for (int g = 0; g < groups; g++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       begin c = 4'h5; r = $urandom_range(1, 17); end
        1:       begin c = 4'h6; r = $urandom_range(1, 20); end
        default: begin c = 4'hF; r = $urandom_range(1, 5);  end
      endcase
      for (int j = 0; j < r; j++) sync_q.push_back(c);
    end
    kind = $urandom_range(0, 19);
    if (kind < 14)      sync_q.push_back(4'h0);
    else if (kind < 17) sync_q.push_back(4'hA);
    else                sync_q.push_back(bad_codes[$urandom_range(0, 10)]);
  endtask

  task automatic reset_mid_addr();
    #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h1234; bus.req_wdata = 8'h77;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_addr_oe", 32'({bus.lad_oe, bus.busy}), 32'(2'b11));
    lpc_rst = 1'b0;
    #1;
    chk("rst_immediate",
        32'({bus.lframe_n, bus.lad_oe, bus.busy, bus.rsp_valid, bus.req_ready, bus.lad_out}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF}));
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_no_rsp", 32'(bus.rsp_valid), 32'(0));
    end
    #2 lpc_rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_release_idle", 32'({bus.req_ready, bus.busy}), 32'(2'b10));
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'({bus.rsp_valid, bus.busy}), 32'(0));
    end
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.lad_in = 4'hF;
    lpc_rst = 1'b0;
    #3;
    chk("reset_outputs",
        32'({bus.lframe_n, bus.lad_oe, bus.lad_out, bus.rsp_valid, bus.rsp_rdata,
             bus.rsp_err, bus.busy, bus.req_ready}),
        32'({1'b1, 1'b0, 4'hF, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1}));
    repeat (2) @(posedge clk);
    #2 lpc_rst = 1'b1;
    @(posedge clk);
    #1 chk("first_edge_ready", 32'({bus.req_ready, bus.busy}), 32'(2'b10));

    // Zero-wait write 0x03F8 = 0x5A
    sync_q = {4'h0};
    run_txn(1'b1, 16'h03F8, 8'h5A, 8'h00, 1'b0);
    // Read 0x03FD with two short waits, data 0x60
    sync_q = {4'h5, 4'h5, 4'h0};
    run_txn(1'b0, 16'h03FD, 8'h00, 8'h60, 1'b0);
    // No response: LAD held at 0xF
    sync_q = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    run_txn(1'b0, 16'h0060, 8'h00, 8'hAA, 1'b0);
    // Target error SYNC with data 0x3C
    sync_q = {4'hA};
    run_txn(1'b0, 16'h0064, 8'h00, 8'h3C, 1'b0);
    // Short-wait timeout, long wait without limit, illegal SYNC code
    sync_q = {};
    for (int i = 0; i < SHORT; i++) sync_q.push_back(4'h5);
    run_txn(1'b1, 16'h0070, 8'h11, 8'h00, 1'b0);
    sync_q = {};
    for (int i = 0; i < 40; i++) sync_q.push_back(4'h6);
    sync_q.push_back(4'h0);
    run_txn(1'b0, 16'h0071, 8'h00, 8'hC5, 1'b0);
    sync_q = {4'hF, 4'hF, 4'hF, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0};
    run_txn(1'b0, 16'h0072, 8'h00, 8'h96, 1'b0);
    sync_q = {4'h6, 4'h3};
    run_txn(1'b1, 16'h0073, 8'h22, 8'h00, 1'b0);

    // Reset during the third address cycle, then a normal write
    reset_mid_addr();
    sync_q = {4'h0};
    run_txn(1'b1, 16'h0080, 8'hC3, 8'h00, 1'b0);

    // req_valid held through a write: next request taken right after DONE
    sync_q = {4'h0};
    run_txn(1'b1, 16'h2E2F, 8'hE7, 8'h00, 1'b1);
    sync_q = {4'h0};
    run_txn(1'b0, 16'h2E2E, 8'h00, 8'h5D, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      gen_sync();
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)));
    end
    #1 bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 Parameter NORESP_LIMIT, default 4: consecutive SYNC cycles reading 0xF before the cycle is aborted.
REQ-002 Parameter SHORT_LIMIT, default 16: consecutive SYNC cycles reading 0x5 before the cycle is aborted; 0x6 (long wait) has no limit.
REQ-003 One clock and one asynchronous active-low reset: clk is the LPC clock and lpc_rst is the reset; the block SHALL act on clk rising edges only.
REQ-004 clk  in  1  LPC clock; all state and LPC outputs change on its rising edge.
REQ-005 lpc_rst  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  host I/O request pending.
REQ-007 req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-008 req_write  in  1  1 = IOWR, 0 = IORD.
REQ-009 req_addr  in  16  I/O address, sampled at acceptance.
REQ-010 req_wdata  in  8  write data, sampled at acceptance.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  8  read data, valid while rsp_valid is high; 0x00 for writes.
REQ-013 rsp_err  out  2  00 ok, 01 no response/timeout, 10 target error SYNC (0xA).
REQ-014 lad_in  in  4  LAD[3:0] as seen from the pads.
REQ-015 lad_out  out  4  value driven on LAD[3:0] when lad_oe is high.
REQ-016 lad_oe  out  1  LAD output enable.
REQ-017 lframe_n  out  1  LFRAME#, active low.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, START, CTDIR, ADDR, WDATA, TAR_H1, TAR_H2, SYNC, RDATA, TAR_T1, TAR_T2, DONE, ABORT.
REQ-020 Acceptance moves IDLE->START; START drives lframe_n=0, lad_out=0x0, lad_oe=1.
REQ-021 CTDIR drives lframe_n=1, lad_out=0x2 for writes and 0x0 for reads.
REQ-022 ADDR lasts 4 cycles and drives address nibbles MSB first: [15:12], [11:8], [7:4], [3:0].
REQ-023 Writes go through WDATA for 2 cycles, low nibble first, then TAR_H1; reads go directly from ADDR to TAR_H1.
REQ-024 TAR_H1 drives lad_out=0xF with lad_oe=1; TAR_H2 has lad_oe=0; lad_oe SHALL stay 0 from TAR_H2 through DONE.
REQ-025 SYNC samples lad_in every cycle:
  - 0x0 ends SYNC: read goes to RDATA, write goes to TAR_T1, err=00.
  - 0xA ends SYNC the same way with err=10.
  - 0x5 or 0x6 stays in SYNC.
  - 0xF stays in SYNC.
  - Any other value goes to ABORT with err=01.
REQ-026 The wait counter resets on entry to SYNC and on any change of the sampled code.
  - NORESP_LIMIT consecutive 0xF samples go to ABORT, err=01.
  - SHORT_LIMIT consecutive 0x5 samples go to ABORT, err=01.
REQ-027 RDATA lasts 2 cycles and captures lad_in as rsp_rdata[3:0] then rsp_rdata[7:4].
REQ-028 TAR_T1 and TAR_T2 last one cycle each, then DONE.
REQ-029 DONE pulses rsp_valid for one cycle with rsp_rdata and rsp_err, then returns to IDLE.
REQ-030 ABORT drives lframe_n=0 and lad_out=0xF with lad_oe=1 for 4 cycles, then goes to DONE with err=01 and rdata=0x00.
REQ-031 Zero-wait latency: 13 bus cycles from the cycle after acceptance; rsp_valid is high in the 14th cycle after acceptance.
REQ-032 req_valid while busy SHALL be ignored, with no queuing.
REQ-033 A new request can be accepted in the cycle after DONE.

Reset
REQ-034 Asserting lpc_rst SHALL immediately force:
  - state IDLE;
  - lframe_n=1, lad_oe=0, lad_out=0xF;
  - rsp_valid=0, rsp_rdata=0x00, rsp_err=00;
  - busy=0, all counters 0.
REQ-035 Reset mid-cycle SHALL produce no rsp_valid pulse, and the aborted request SHALL be lost.
REQ-036 On the first edge after deassertion the block SHALL be in IDLE with req_ready=1.

Verification
REQ-037 Write 0x03F8=0x5A, target returns SYNC 0x0 in the first SYNC cycle -> lad_out sequence 0,2,0,3,F,8,A,5,F; lframe_n low in cycle 1 only; rsp_valid in cycle 14; err=00.
REQ-038 Read 0x03FD, target returns 0x5, 0x5, 0x0 then data nibbles 0x0, 0x6 -> rsp_rdata=0x60, err=00, rsp_valid in cycle 16.
REQ-039 Read with lad_in held at 0xF -> 4 SYNC cycles, then lframe_n=0 for 4 cycles, then rsp_err=01 and rsp_rdata=0x00.
REQ-040 Read with SYNC 0xA and data 0x3C -> rsp_rdata=0x3C, rsp_err=10, normal 13-cycle length.
REQ-041 Assert lpc_rst during the third ADDR cycle -> lframe_n=1 and lad_oe=0 immediately; no rsp_valid; after release a write to 0x0080 completes normally.
REQ-042 Hold req_valid high through an entire write -> second request accepted only in the cycle after DONE; req_ready=0 throughout busy.
